// File: rtl/core_mem_arbiter_pkg.sv
// Shared micro-architecture types for the core memory path.
// A mem_req bundles one captured request from either requester.
package core_mem_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [29:0] ptr_t;

  typedef struct packed {
    logic       write;
    ptr_t       addr;
    word_t      data;
    logic [3:0] be;
  } mem_req_t;

  function automatic word_t byte_addr(ptr_t p);
    return {p, 2'b00};
  endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Avalon-MM style bus between the arbiter (master) and the memory (slave).
interface core_mem_arbiter_if;
  import core_mem_arbiter_pkg::*;

  word_t      avl_address;
  logic       avl_read;
  logic       avl_write;
  word_t      avl_writedata;
  logic [3:0] avl_byteenable;
  logic       avl_waitrequest;
  word_t      avl_readdata;
  logic       avl_readdatavalid;

  modport master (
    output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    input  avl_waitrequest, avl_readdata, avl_readdatavalid
  );

  modport slave (
    input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    output avl_waitrequest, avl_readdata, avl_readdatavalid
  );
endinterface

// File: rtl/core_mem_req_latch.sv
// Per-requester capture register with pending flag.
// A fresh start is visible combinationally so an idle arbiter can grant it at once.
module core_mem_req_latch
  import core_mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  logic     busy,
  input  logic     grant,
  input  mem_req_t req_in,
  output logic     valid,
  output mem_req_t req
);

  logic     pending_r;
  mem_req_t req_r;
  logic     take_s;

  // Starts are dropped while this requester already has work queued or on the bus.
  assign take_s = start & ~busy & ~pending_r;

  // Pending flag and captured request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 1'b0;
      req_r     <= '0;
    end else begin
      if (grant) begin
        pending_r <= 1'b0;
      end else if (take_s) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      if (take_s) begin
        req_r <= req_in;
      end else begin
        req_r <= req_r;
      end
    end
  end

  // Present either the held request or the one arriving this cycle.
  always_comb begin
    valid = pending_r | take_s;
    if (pending_r) begin
      req = req_r;
    end else begin
      req = req_in;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one Avalon-MM master.
// Data wins ties; a saturating counter forces a fetch after STARVE_LIMIT data grants.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       insn_start,
  input  ptr_t       insn_addr,
  output logic       insn_ready,
  output word_t      insn_data_rd,
  input  logic       data_start,
  input  logic       data_write,
  input  ptr_t       data_addr,
  input  word_t      data_data_wr,
  input  logic [3:0] data_data_be,
  output logic       data_ready,
  output word_t      data_data_rd,
  core_mem_arbiter_if.master avl
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t     state_r, state_n;
  logic       gnt_insn_r;
  logic [7:0] starve_cnt_r;
  logic       insn_valid_s, data_valid_s, insn_busy_s, data_busy_s;
  mem_req_t   insn_req_s, data_req_s, gnt_req_s;
  logic       grant_insn_s, grant_data_s, accept_s, wr_done_s, rd_done_s;

  assign insn_busy_s = (state_r != IDLE) &  gnt_insn_r;
  assign data_busy_s = (state_r != IDLE) & ~gnt_insn_r;

  core_mem_req_latch u_insn_latch (
    .clk(clk), .rst(rst), .start(insn_start), .busy(insn_busy_s), .grant(grant_insn_s),
    .req_in('{write: 1'b0, addr: insn_addr, data: 32'h0, be: 4'h0}),
    .valid(insn_valid_s), .req(insn_req_s)
  );

  core_mem_req_latch u_data_latch (
    .clk(clk), .rst(rst), .start(data_start), .busy(data_busy_s), .grant(grant_data_s),
    .req_in('{write: data_write, addr: data_addr, data: data_data_wr, be: data_data_be}),
    .valid(data_valid_s), .req(data_req_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (insn_valid_s | data_valid_s) state_n = ISSUE;
        else                             state_n = IDLE;
      end
      ISSUE: begin
        if (avl.avl_waitrequest)                            state_n = ISSUE;
        else if (avl.avl_write | avl.avl_readdatavalid)     state_n = IDLE;
        else                                                state_n = WAIT_RD;
      end
      WAIT_RD: begin
        if (avl.avl_readdatavalid) state_n = IDLE;
        else                       state_n = WAIT_RD;
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant and completion decode.
  always_comb begin
    grant_insn_s = 1'b0;
    grant_data_s = 1'b0;
    accept_s     = 1'b0;
    wr_done_s    = 1'b0;
    rd_done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (insn_valid_s && (!data_valid_s || (LIMIT != 8'd0 && starve_cnt_r == LIMIT))) begin
          grant_insn_s = 1'b1;
        end else if (data_valid_s) begin
          grant_data_s = 1'b1;
        end else begin
          grant_data_s = 1'b0;
        end
      end
      ISSUE: begin
        accept_s = ~avl.avl_waitrequest;
        if (accept_s && avl.avl_write) begin
          wr_done_s = 1'b1;
        end else if (accept_s && avl.avl_readdatavalid) begin
          rd_done_s = 1'b1;
        end else begin
          rd_done_s = 1'b0;
        end
      end
      WAIT_RD: rd_done_s = avl.avl_readdatavalid;
      default: rd_done_s = 1'b0;
    endcase
    if (grant_insn_s) gnt_req_s = insn_req_s;
    else              gnt_req_s = data_req_s;
  end

  // Registered bus outputs, ready pulses, read data and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_insn_r         <= 1'b0;
      starve_cnt_r       <= 8'd0;
      avl.avl_address    <= 32'h0;
      avl.avl_read       <= 1'b0;
      avl.avl_write      <= 1'b0;
      avl.avl_writedata  <= 32'h0;
      avl.avl_byteenable <= 4'h0;
      insn_ready         <= 1'b0;
      insn_data_rd       <= 32'h0;
      data_ready         <= 1'b0;
      data_data_rd       <= 32'h0;
    end else begin
      insn_ready <= 1'b0;
      data_ready <= 1'b0;
      if (grant_insn_s | grant_data_s) begin
        gnt_insn_r         <= grant_insn_s;
        avl.avl_address    <= byte_addr(gnt_req_s.addr);
        avl.avl_read       <= ~gnt_req_s.write;
        avl.avl_write      <=  gnt_req_s.write;
        avl.avl_writedata  <= gnt_req_s.write ? gnt_req_s.data : 32'h0;
        avl.avl_byteenable <= gnt_req_s.write ? gnt_req_s.be : 4'hF;
      end else if (accept_s) begin
        avl.avl_read  <= 1'b0;
        avl.avl_write <= 1'b0;
      end
      if (wr_done_s) data_ready <= 1'b1;
      if (rd_done_s) begin
        if (gnt_insn_r) begin
          insn_ready   <= 1'b1;
          insn_data_rd <= avl.avl_readdata;
        end else begin
          data_ready   <= 1'b1;
          data_data_rd <= avl.avl_readdata;
        end
      end
      // Count data wins over a waiting fetch; any fetch grant or idle fetch side resets it.
      if (grant_insn_s || !insn_valid_s) begin
        starve_cnt_r <= 8'd0;
      end else if (grant_data_s && starve_cnt_r != LIMIT) begin
        starve_cnt_r <= starve_cnt_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a cycle table plus starvation and reset sequences.
module tb_core_mem_arbiter;
  import core_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic insn_start, data_start, data_write;
  ptr_t insn_addr, data_addr;
  word_t data_data_wr, insn_data_rd, data_data_rd;
  logic [3:0] data_data_be;
  logic insn_ready, data_ready;
  int total = 0;
  int bad = 0;

  core_mem_arbiter_if avl ();

  core_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .insn_start(insn_start), .insn_addr(insn_addr), .insn_ready(insn_ready), .insn_data_rd(insn_data_rd),
    .data_start(data_start), .data_write(data_write), .data_addr(data_addr),
    .data_data_wr(data_data_wr), .data_data_be(data_data_be),
    .data_ready(data_ready), .data_data_rd(data_data_rd),
    .avl(avl.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic is; logic [29:0] ia;
    logic ds; logic dw; logic [29:0] da; logic [31:0] dd; logic [3:0] db;
    logic wq; logic rdv; logic [31:0] rdat;
    logic e_rd; logic e_wr; logic [31:0] e_addr; logic [3:0] e_be; logic [31:0] e_wdata;
    logic e_ir; logic e_dr; logic [31:0] e_data;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd"},   {31'h0, avl.avl_read}, 32'h0);
    chk({tag, "_wr"},   {31'h0, avl.avl_write}, 32'h0);
    chk({tag, "_addr"}, avl.avl_address, 32'h0);
    chk({tag, "_be"},   {28'h0, avl.avl_byteenable}, 32'h0);
    chk({tag, "_wd"},   avl.avl_writedata, 32'h0);
    chk({tag, "_ir"},   {31'h0, insn_ready}, 32'h0);
    chk({tag, "_dr"},   {31'h0, data_ready}, 32'h0);
    chk({tag, "_idat"}, insn_data_rd, 32'h0);
    chk({tag, "_ddat"}, data_data_rd, 32'h0);
  endtask

  initial begin
    int nwr;
    logic got_read;
    logic seen;

    // is ia  ds dw da dd db  wq rdv rdat | e_rd e_wr e_addr e_be e_wdata e_ir e_dr e_data
    vecs[0]  = '{1'b1, 30'h10, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEADBEEF,
                 1'b0, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 30'h20, 1'b1, 1'b1, 30'h4, 32'h1234, 4'b0011, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h10, 4'b0011, 32'h1234, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h10, 4'b0011, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h80, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D,
                 1'b0, 1'b0, 32'h80, 4'hF, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D};
    vecs[7]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h80, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 30'h0, 1'b1, 1'b0, 30'h3, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'hC, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'hC, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[10] = vecs[9];
    vecs[11] = vecs[9];
    vecs[12] = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'hC, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[13] = vecs[12];
    vecs[14] = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h55AA55AA,
                 1'b0, 1'b0, 32'hC, 4'hF, 32'h0, 1'b0, 1'b1, 32'h55AA55AA};
    vecs[15] = '{1'b0, 30'h0, 1'b1, 1'b1, 30'h8, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h20, 4'hF, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b1, 32'h55AA55AA};
    vecs[17] = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};

    rst = 1'b1;
    insn_start = 1'b0; insn_addr = '0;
    data_start = 1'b0; data_write = 1'b0; data_addr = '0; data_data_wr = '0; data_data_be = '0;
    avl.avl_waitrequest = 1'b0; avl.avl_readdata = '0; avl.avl_readdatavalid = 1'b0;
    tick();
    tick();
    chk_outputs_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      insn_start = vecs[i].is; insn_addr = vecs[i].ia;
      data_start = vecs[i].ds; data_write = vecs[i].dw; data_addr = vecs[i].da;
      data_data_wr = vecs[i].dd; data_data_be = vecs[i].db;
      avl.avl_waitrequest = vecs[i].wq; avl.avl_readdatavalid = vecs[i].rdv;
      avl.avl_readdata = vecs[i].rdat;
      tick();
      chk($sformatf("v%0d_rd", i), {31'h0, avl.avl_read}, {31'h0, vecs[i].e_rd});
      chk($sformatf("v%0d_wr", i), {31'h0, avl.avl_write}, {31'h0, vecs[i].e_wr});
      chk($sformatf("v%0d_addr", i), avl.avl_address, vecs[i].e_addr);
      chk($sformatf("v%0d_be", i), {28'h0, avl.avl_byteenable}, {28'h0, vecs[i].e_be});
      chk($sformatf("v%0d_ir", i), {31'h0, insn_ready}, {31'h0, vecs[i].e_ir});
      chk($sformatf("v%0d_dr", i), {31'h0, data_ready}, {31'h0, vecs[i].e_dr});
      if (vecs[i].e_wr) chk($sformatf("v%0d_wdata", i), avl.avl_writedata, vecs[i].e_wdata);
      if (vecs[i].e_ir) chk($sformatf("v%0d_idata", i), insn_data_rd, vecs[i].e_data);
      if (vecs[i].e_dr) chk($sformatf("v%0d_ddata", i), data_data_rd, vecs[i].e_data);
    end

    // Starvation: data restarted on every data_ready while a fetch waits.
    insn_start = 1'b1; insn_addr = 30'h30;
    data_start = 1'b1; data_write = 1'b1; data_addr = 30'h100; data_data_wr = 32'h1; data_data_be = 4'hF;
    avl.avl_waitrequest = 1'b0; avl.avl_readdatavalid = 1'b0;
    tick();
    insn_start = 1'b0;
    nwr = 0;
    got_read = 1'b0;
    for (int c = 0; c < 60 && !got_read; c++) begin
      data_start = 1'b0;
      if (avl.avl_write) nwr++;
      if (avl.avl_read) begin
        got_read = 1'b1;
      end else begin
        if (data_ready) data_start = 1'b1;
        tick();
      end
    end
    chk("starve_fetch_granted", {31'h0, got_read}, 32'h1);
    chk("starve_data_grants", nwr, 32'd4);
    chk("starve_fetch_addr", avl.avl_address, 32'hC0);
    avl.avl_readdatavalid = 1'b1; avl.avl_readdata = 32'h0BADCAFE;
    tick();
    avl.avl_readdatavalid = 1'b0;
    chk("starve_fetch_ready", {31'h0, insn_ready}, 32'h1);
    chk("starve_fetch_data", insn_data_rd, 32'h0BADCAFE);
    chk("starve_cnt_cleared", {24'h0, dut.starve_cnt_r}, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (data_ready) seen = 1'b1;
    end
    chk("starve_pending_data_done", {31'h0, seen}, 32'h1);
    tick();

    // Reset while waiting for read data, then a stray readdatavalid.
    insn_start = 1'b1; insn_addr = 30'h44;
    tick();
    insn_start = 1'b0;
    chk("rst_seq_strobe", {31'h0, avl.avl_read}, 32'h1);
    tick();
    chk("rst_seq_wait_rd", {30'h0, dut.state_r}, 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outputs_zero("midrst");
    avl.avl_readdatavalid = 1'b1; avl.avl_readdata = 32'hBAD0BAD0;
    tick();
    avl.avl_readdatavalid = 1'b0;
    chk("stray_ir", {31'h0, insn_ready}, 32'h0);
    chk("stray_dr", {31'h0, data_ready}, 32'h0);
    chk("stray_idle", {30'h0, dut.state_r}, 32'h0);
    insn_start = 1'b1; insn_addr = 30'h11;
    tick();
    insn_start = 1'b0;
    chk("post_rst_rd", {31'h0, avl.avl_read}, 32'h1);
    chk("post_rst_addr", avl.avl_address, 32'h44);
    avl.avl_readdatavalid = 1'b1; avl.avl_readdata = 32'h600DF00D;
    tick();
    avl.avl_readdatavalid = 1'b0;
    chk("post_rst_ir", {31'h0, insn_ready}, 32'h1);
    chk("post_rst_data", insn_data_rd, 32'h600DF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
